// File: rtl/spike_delay_bank.sv
// spike_delay_bank: per-channel programmable axonal delay lines,
// short/long combine, and tick-latched saturating spike counters.
module spike_delay_bank #(
  parameter int NCH        = 4,
  parameter int ADDR_W     = 10,
  parameter int DEPTH      = 1024,
  parameter int CNT_W      = 32,
  parameter int DELAY_INIT = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [NCH-1:0]       spike_in,
  input  logic [ADDR_W-1:0]    delay_in,
  input  logic                 delay_load,
  input  logic [1:0]           mode,
  input  logic                 tick,
  output logic [NCH-1:0]       spike_delayed,
  output logic [NCH-1:0]       spike_out,
  output logic [NCH*CNT_W-1:0] cnt_out,
  output logic                 armed
);

  // Array is sized to the full address space so any pointer
  // width indexes it cleanly; only 0..DEPTH-1 is ever touched.
  localparam int MEM_N = 1 << ADDR_W;

  localparam int D_INIT_C =
    (DELAY_INIT < 1)      ? 1 :
    (DELAY_INIT >= DEPTH) ? DEPTH - 1 :
                            DELAY_INIT;

  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   FILL_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] D_MAX    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] D_MIN    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] D_RST    = ADDR_W'(D_INIT_C);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  logic [NCH-1:0]    mem [MEM_N];

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] d_q;
  logic [ADDR_W-1:0] d_nx;
  logic [ADDR_W-1:0] d_req;
  logic [ADDR_W:0]   fill;
  logic [ADDR_W:0]   fill_nx;
  logic              fill_ok;
  logic [NCH-1:0]    dly;
  logic [NCH-1:0]    comb_nx;

  logic [CNT_W-1:0]  cnt    [NCH];
  logic [CNT_W-1:0]  cnt_nx [NCH];

  // Clamp the requested delay into 1..DEPTH-1.
  always_comb begin
    d_req = delay_in;
    if (delay_in == '0)
      d_req = D_MIN;
    else if ({1'b0, delay_in} >= DEPTH_W)
      d_req = D_MAX;
  end

  // Read pointer D steps behind the writer, wrapping at DEPTH.
  always_comb begin
    if (wr_ptr >= d_q)
      rd_ptr = wr_ptr - d_q;
    else
      rd_ptr = ADDR_W'({1'b0, wr_ptr} + DEPTH_W
                       - {1'b0, d_q});
  end

  // Delayed tap, masked until D valid entries exist.
  always_comb begin
    fill_ok = (fill >= {1'b0, d_q});
    dly     = fill_ok ? mem[rd_ptr] : '0;
  end

  // Short/long combine selected by mode.
  always_comb begin
    comb_nx = spike_in | dly;
    unique case (mode)
      2'd0:    comb_nx = spike_in;
      2'd1:    comb_nx = dly;
      default: comb_nx = spike_in | dly;
    endcase
  end

  // Next fill level and delay; a load overrides the step.
  always_comb begin
    fill_nx = fill;
    d_nx    = d_q;
    if (en && (fill != DEPTH_W))
      fill_nx = fill + FILL_ONE;
    if (delay_load) begin
      fill_nx = '0;
      d_nx    = d_req;
    end
  end

  // Saturating per-channel increment for the current step.
  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      cnt_nx[ch] = cnt[ch];
      if (en && comb_nx[ch] && (cnt[ch] != CNT_MAX))
        cnt_nx[ch] = cnt[ch] + CNT_ONE;
    end
  end

  // Spike buffer write; contents need no reset.
  always_ff @(posedge clk) begin
    if (en)
      mem[wr_ptr] <= spike_in;
  end

  // Pointer, fill, delay and registered spike outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      fill          <= '0;
      d_q           <= D_RST;
      armed         <= 1'b0;
      spike_delayed <= '0;
      spike_out     <= '0;
    end else begin
      fill  <= fill_nx;
      d_q   <= d_nx;
      armed <= (fill_nx >= {1'b0, d_nx});
      if (en) begin
        wr_ptr        <= (wr_ptr == PTR_LAST) ? '0
                         : wr_ptr + PTR_ONE;
        spike_delayed <= dly;
        spike_out     <= comb_nx;
      end
    end
  end

  // Counters: accumulate, latch and clear on tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_out <= '0;
      for (int ch = 0; ch < NCH; ch++)
        cnt[ch] <= '0;
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (tick) begin
          cnt_out[ch*CNT_W +: CNT_W] <= cnt_nx[ch];
          cnt[ch]                    <= '0;
        end else begin
          cnt[ch] <= cnt_nx[ch];
        end
      end
    end
  end

endmodule
